// File: rtl/sfx_event_queue.sv
// sfx_event_queue: edge-detects game events, queues sound effects and drives timed synth requests
module sfx_event_queue #(
  parameter int TICK_DIV = 50000,
  parameter int JUMP_TICKS = 2,
  parameter int SCORE_TICKS = 1,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic jump_btn,
  input  logic score_evt,
  input  logic collide,
  input  logic restart,
  output logic jump,
  output logic score,
  output logic gameover,
  output logic busy,
  output logic dropped,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int aw = $clog2(DEPTH);
  localparam int cw = aw + 1;
  localparam int tw = $clog2((JUMP_TICKS > SCORE_TICKS ? JUMP_TICKS : SCORE_TICKS) + 1);
  localparam int dw = $clog2(TICK_DIV);
  localparam logic [cw:0] full_lvl = (cw + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state;
  logic jump_q, score_q, coll_q, coll_p;
  logic [DEPTH-1:0] mem;
  logic [aw-1:0] rp, wp;
  logic [dw-1:0] div;
  logic [tw-1:0] timer;
  logic jump_e, score_e, push_en, pop, acc_j, acc_s, tick, head, rst_div;
  logic [cw:0] cnt_x;
  always_comb begin
    jump_e = jump_btn & ~jump_q;
    score_e = score_evt & ~score_q;
    push_en = state != OVER;
    pop = enable && !coll_p && state == IDLE && fifo_count != '0;
    cnt_x = {1'b0, fifo_count};
    acc_j = push_en && jump_e && (cnt_x < full_lvl + (cw + 1)'(pop));
    acc_s = push_en && score_e && (cnt_x + (cw + 1)'(acc_j) < full_lvl + (cw + 1)'(pop));
    tick = enable && div == dw'(TICK_DIV - 1);
    head = mem[rp];
    rst_div = enable && !coll_p && state == OVER && restart;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_q <= 1'b0;
      score_q <= 1'b0;
      coll_q <= 1'b0;
      coll_p <= 1'b0;
    end else begin
      jump_q <= jump_btn;
      score_q <= score_evt;
      coll_q <= collide;
      coll_p <= collide & ~coll_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || coll_p) begin
      rp <= '0;
      wp <= '0;
      fifo_count <= '0;
    end else begin
      if (acc_j) mem[wp] <= 1'b0;
      if (acc_s) mem[wp + aw'(acc_j)] <= 1'b1;
      wp <= wp + aw'(acc_j) + aw'(acc_s);
      rp <= rp + aw'(pop);
      fifo_count <= fifo_count + cw'(acc_j) + cw'(acc_s) - cw'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) dropped <= 1'b0;
    else if ((jump_e && push_en && !acc_j) || (score_e && push_en && !acc_s)) dropped <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset || rst_div) div <= '0;
    else if (enable) div <= tick ? '0 : div + dw'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      jump <= 1'b0;
      score <= 1'b0;
      gameover <= 1'b0;
      busy <= 1'b0;
    end else if (coll_p) begin
      state <= OVER;
      timer <= '0;
      jump <= 1'b0;
      score <= 1'b0;
      gameover <= 1'b1;
      busy <= 1'b1;
    end else if (enable) begin
      if (pop) begin
        state <= PLAY;
        busy <= 1'b1;
        jump <= ~head;
        score <= head;
        timer <= head ? tw'(SCORE_TICKS) : tw'(JUMP_TICKS);
      end else if (state == PLAY && tick) begin
        if (timer == tw'(1)) begin
          state <= IDLE;
          busy <= 1'b0;
          jump <= 1'b0;
          score <= 1'b0;
        end else timer <= timer - tw'(1);
      end else if (state == OVER && restart) begin
        state <= IDLE;
        busy <= 1'b0;
        gameover <= 1'b0;
      end
    end
  end
endmodule
